sequential_adder_ctrl: RTL and testbench

Multi-cycle wide-word adder controller. It captures two NUM_WORDS×16-bit operands and sequences one shared `adder_16bit` instance across all 16-bit slices, least significant word first, one slice per clock. The carry-out of each slice is registered and fed into the next slice. Completion is signalled with a start/busy/done handshake. The block sits between a control unit issuing wide additions and the single 16-bit adder datapath.

---
 rtl/sequential_adder_ctrl.sv | 120 ++++++++++++
 tb/tb_sequential_adder_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sequential_adder_ctrl.sv
// Multi-cycle wide adder: one shared 16-bit adder walks the operand slices LSW first,
// carrying between slices through a register, with a start/busy/done handshake.

module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        overflow
);

    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};

endmodule

module sequential_adder_ctrl #(
    parameter int unsigned NUM_WORDS = 4,
    localparam int unsigned W = 16 * NUM_WORDS,
    localparam int unsigned CntW = $clog2(NUM_WORDS)
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    output logic [W-1:0] sum,
    output logic         overflow,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_WORDS - 1);

    state_e          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic            ovf_q;
    logic            busy_q;
    logic            done_q;
    logic [CntW-1:0] cnt_q;

    logic [15:0]     slice_a;
    logic [15:0]     slice_b;
    logic [15:0]     slice_sum;
    logic            slice_cout;

    always_comb begin
        slice_a = a_q[cnt_q*16 +: 16];
        slice_b = b_q[cnt_q*16 +: 16];
    end

    adder_16bit u_adder (
        .a        (slice_a),
        .b        (slice_b),
        .carry_in (carry_q),
        .sum      (slice_sum),
        .overflow (slice_cout)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= carry_in;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    sum_q[cnt_q*16 +: 16] <= slice_sum;
                    carry_q               <= slice_cout;
                    if (cnt_q == LastCnt) begin
                        ovf_q   <= slice_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign sum      = sum_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sequential_adder_ctrl.sv
// Directed bench for sequential_adder_ctrl (NUM_WORDS=4): reset, carry ripple,
// ignored start, mid-operation reset and back-to-back issue.

module tb_sequential_adder_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        carry_in;
    logic [63:0] sum;
    logic        overflow;
    logic        busy;
    logic        done;

    int total  = 0;
    int passes = 0;

    logic [63:0] av [4];
    logic [63:0] bv [4];
    logic        cv [4];
    logic [63:0] sv [4];
    logic        ov [4];

    sequential_adder_ctrl #(.NUM_WORDS(4)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
        .sum      (sum),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one op at the next edge, then check busy for 4 cycles, done, result, return to idle.
    task automatic run_op(input string tag, input logic [63:0] oa, input logic [63:0] ob,
                          input logic oc, input logic [63:0] es, input logic eo);
        a = oa; b = ob; carry_in = oc; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            a = ~oa; b = ~ob; carry_in = ~oc;
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            chk({tag, "_nodone"}, 64'(done), 64'd0);
        end
        @(negedge clk);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
        @(negedge clk);
        chk({tag, "_done_once"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_sum_hold"}, sum, es);
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_sum", sum, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        n_rst = 1'b1;
        @(negedge clk);

        run_op("slice_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
               64'h0000_0000_0001_0000, 1'b0);
        run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);

        // Start pulses during busy and done must be ignored.
        a = 64'h1234_0000_0000_0001; b = 64'h0001_0000_0000_0001; carry_in = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555; carry_in = 1'b1;
        chk("ign_busy", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("ign_nodone", 64'(done), 64'd0);
        @(negedge clk);
        chk("ign_done", 64'(done), 64'd1);
        chk("ign_sum", sum, 64'h1235_0000_0000_0002);
        chk("ign_ovf", 64'(overflow), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_idle_busy", 64'(busy), 64'd0);
        chk("ign_idle_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("ign_no_restart", 64'(busy), 64'd0);
        chk("ign_sum_hold", sum, 64'h1235_0000_0000_0002);

        // Reset mid-operation, right after the edge that sets cnt=2.
        a = 64'h0000_0000_0003_0001; b = 64'h0000_0000_0004_0002; carry_in = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_slice0", sum, 64'h0000_0000_0000_0003);
        @(posedge clk);
        #1;
        chk("mid_slice1", sum, 64'h0000_0000_0007_0003);
        #1 n_rst = 1'b0;
        #1;
        chk("mid_rst_sum", sum, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_hold_done", 64'(done), 64'd0);
        end
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_after_done", 64'(done), 64'd0);
            chk("mid_after_busy", 64'(busy), 64'd0);
        end
        run_op("msb_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
               64'h0, 1'b1);

        // Continuous start: a new op every 6 cycles with the operands present at acceptance.
        av[0] = 64'h0000_0000_0000_0001; bv[0] = 64'h0000_0000_0000_0002; cv[0] = 1'b0;
        sv[0] = 64'h0000_0000_0000_0003; ov[0] = 1'b0;
        av[1] = 64'hFFFF_0000_0000_0000; bv[1] = 64'h0001_0000_0000_0000; cv[1] = 1'b0;
        sv[1] = 64'h0000_0000_0000_0000; ov[1] = 1'b1;
        av[2] = 64'h0000_FFFF_FFFF_FFFF; bv[2] = 64'h0;                   cv[2] = 1'b1;
        sv[2] = 64'h0001_0000_0000_0000; ov[2] = 1'b0;
        av[3] = 64'h1111_2222_3333_4444; bv[3] = 64'h1111_1111_1111_1111; cv[3] = 1'b0;
        sv[3] = 64'h2222_3333_4444_5555; ov[3] = 1'b0;
        a = av[0]; b = bv[0]; carry_in = cv[0]; start = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j < 3) begin
                a = av[j+1]; b = bv[j+1]; carry_in = cv[j+1];
            end else begin
                start = 1'b0; a = '1; b = '1; carry_in = 1'b1;
            end
            chk("cont_busy", 64'(busy), 64'd1);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("cont_nodone", 64'(done), 64'd0);
            end
            @(negedge clk);
            chk("cont_done", 64'(done), 64'd1);
            chk("cont_sum", sum, sv[j]);
            chk("cont_ovf", 64'(overflow), 64'(ov[j]));
            @(negedge clk);
            chk("cont_idle_busy", 64'(busy), 64'd0);
            chk("cont_idle_done", 64'(done), 64'd0);
        end
        @(negedge clk);
        chk("cont_stopped", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
